// File: rtl/vision_grid_detect.sv
// Per-cell foreground counter for RGB565 video with per-frame snapshot and a scan FSM
// that publishes cell hit flags plus the lane/jump decision once per frame.
module vision_grid_detect #(
    parameter int unsigned FRAME_WIDTH     = 320,
    parameter int unsigned FRAME_HEIGHT    = 240,
    parameter int unsigned GRID_COLS       = 3,
    parameter int unsigned GRID_ROWS       = 3,
    parameter int unsigned CHANNEL         = 1,
    parameter int unsigned COLOR_THRESHOLD = 60,
    parameter int unsigned COUNT_THRESHOLD = 64
) (
    input  logic                               pixel_clock_in,
    input  logic                               rst_in,
    input  logic [9:0]                         frame_x_count,
    input  logic [8:0]                         frame_y_count,
    input  logic [15:0]                        pixel_data,
    input  logic                               pixel_valid,
    output logic [GRID_ROWS*GRID_COLS-1:0]     cell_hits,
    output logic [1:0]                         lane,
    output logic                               jump,
    output logic                               data_valid
);

    localparam int unsigned G     = GRID_ROWS * GRID_COLS;
    localparam int unsigned IDX_W = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned COL_W = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int unsigned ROW_W = $clog2(GRID_ROWS);
    localparam int unsigned CT_W  = $clog2(GRID_ROWS + 1);
    localparam int unsigned RT_W  = $clog2(GRID_COLS + 1);
    localparam int unsigned CNT_W = 17;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_TH   = CNT_W'(COUNT_THRESHOLD);
    localparam logic [1:0]       LANE_RST = (GRID_COLS >= 2) ? 2'd1 : 2'd0;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    function automatic logic [IDX_W-1:0] cell_index(input logic [9:0] x, input logic [8:0] y);
        int unsigned col;
        int unsigned row;
        col = 0;
        row = 0;
        for (int unsigned c = 1; c < GRID_COLS; c++)
            if (32'(x) >= c * FRAME_WIDTH / GRID_COLS) col = c;
        for (int unsigned r = 1; r < GRID_ROWS; r++)
            if (32'(y) >= r * FRAME_HEIGHT / GRID_ROWS) row = r;
        return IDX_W'(row * GRID_COLS + col);
    endfunction

    // R and B are 5-bit fields, zero-extended so every channel uses the same 6-bit compare.
    function automatic logic is_fg(input logic [15:0] p);
        logic [5:0] ch;
        case (CHANNEL)
            0:       ch = {1'b0, p[15:11]};
            2:       ch = {1'b0, p[4:0]};
            default: ch = p[10:5];
        endcase
        return 32'(ch) < COLOR_THRESHOLD;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [1:0] lane_pick(input logic [GRID_COLS-1:0][CT_W-1:0] tot);
        int unsigned     best;
        logic [CT_W-1:0] best_n;
        best   = 0;
        best_n = tot[0];
        for (int unsigned c = 1; c < GRID_COLS; c++)
            if (tot[c] > best_n) begin
                best   = c;
                best_n = tot[c];
            end
        return 2'(best);
    endfunction

    logic                               frame_evt;
    logic                               in_frame;
    logic                               inc_p1_q;
    logic                               mark_p1_q;
    logic [IDX_W-1:0]                   idx_p1_q;
    logic                               mark_p2_q;
    logic [CNT_W-1:0]                   live_q   [G];
    logic [CNT_W-1:0]                   shadow_q [G];
    state_t                             state_q, state_d;
    logic [IDX_W-1:0]                   scan_idx_q;
    logic [COL_W-1:0]                   scan_col_q;
    logic [ROW_W-1:0]                   scan_row_q;
    logic [G-1:0]                       hits_acc_q;
    logic [GRID_COLS-1:0][CT_W-1:0]     col_tot_q;
    logic [GRID_ROWS-1:0][RT_W-1:0]     row_tot_q;
    logic                               cur_hit;
    logic [G-1:0]                       cell_hits_q;
    logic [1:0]                         lane_q;
    logic                               jump_q;
    logic                               data_valid_q;

    assign frame_evt = !pixel_valid && (frame_x_count == '0) && (frame_y_count == '0);
    assign in_frame  = (32'(frame_x_count) < FRAME_WIDTH) && (32'(frame_y_count) < FRAME_HEIGHT);

    // ---- stage 1: classify and locate pixel, carry frame marker ----
    always_ff @(posedge pixel_clock_in) begin
        if (rst_in) begin
            inc_p1_q  <= 1'b0;
            idx_p1_q  <= '0;
            mark_p1_q <= 1'b0;
            mark_p2_q <= 1'b0;
        end else begin
            inc_p1_q  <= pixel_valid && in_frame && is_fg(pixel_data);
            idx_p1_q  <= cell_index(frame_x_count, frame_y_count);
            mark_p1_q <= frame_evt;
            mark_p2_q <= mark_p1_q;
        end
    end

    // ---- stage 2: live counters; snapshot keeps the pixel landing on the same edge ----
    always_ff @(posedge pixel_clock_in) begin
        if (rst_in) begin
            for (int i = 0; i < G; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < G; i++) begin
                if (mark_p2_q) begin
                    shadow_q[i] <= live_q[i];
                    live_q[i]   <= (inc_p1_q && idx_p1_q == IDX_W'(i)) ? CNT_W'(1) : '0;
                end else if (inc_p1_q && idx_p1_q == IDX_W'(i)) begin
                    live_q[i] <= sat_inc(live_q[i]);
                end
            end
        end
    end

    // ---- scan FSM ----
    always_ff @(posedge pixel_clock_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            SCAN:    if (scan_idx_q == IDX_W'(G - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (mark_p2_q) state_d = SCAN;
    end

    always_comb begin
        cur_hit = 1'b0;
        for (int i = 0; i < G; i++)
            if (scan_idx_q == IDX_W'(i)) cur_hit = (shadow_q[i] >= CNT_TH);
    end

    always_ff @(posedge pixel_clock_in) begin
        if (rst_in) begin
            scan_idx_q   <= '0;
            scan_col_q   <= '0;
            scan_row_q   <= '0;
            hits_acc_q   <= '0;
            col_tot_q    <= '0;
            row_tot_q    <= '0;
            cell_hits_q  <= '0;
            lane_q       <= LANE_RST;
            jump_q       <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            if (mark_p2_q) begin
                scan_idx_q <= '0;
                scan_col_q <= '0;
                scan_row_q <= '0;
                hits_acc_q <= '0;
                col_tot_q  <= '0;
                row_tot_q  <= '0;
            end else if (state_q == SCAN) begin
                scan_idx_q <= scan_idx_q + 1'b1;
                if (scan_col_q == COL_W'(GRID_COLS - 1)) begin
                    scan_col_q <= '0;
                    scan_row_q <= scan_row_q + 1'b1;
                end else begin
                    scan_col_q <= scan_col_q + 1'b1;
                end
                for (int i = 0; i < G; i++)
                    if (scan_idx_q == IDX_W'(i)) hits_acc_q[i] <= cur_hit;
                if (cur_hit) begin
                    for (int c = 0; c < GRID_COLS; c++)
                        if (scan_col_q == COL_W'(c)) col_tot_q[c] <= col_tot_q[c] + 1'b1;
                    for (int r = 0; r < GRID_ROWS; r++)
                        if (scan_row_q == ROW_W'(r)) row_tot_q[r] <= row_tot_q[r] + 1'b1;
                end
            end else if (state_q == DONE) begin
                cell_hits_q <= hits_acc_q;
                if (|hits_acc_q) lane_q <= lane_pick(col_tot_q);
                jump_q       <= (row_tot_q[0] != '0) && (row_tot_q[GRID_ROWS-1] == '0);
                data_valid_q <= 1'b1;
            end
        end
    end

    assign cell_hits  = cell_hits_q;
    assign lane       = lane_q;
    assign jump       = jump_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_vision_grid_detect.sv
// Directed bench for vision_grid_detect (default 320x240, 3x3 grid, green channel).
module tb_vision_grid_detect;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  fx;
    logic [8:0]  fy;
    logic [15:0] pd;
    logic        pv;
    logic [8:0]  cell_hits;
    logic [1:0]  lane;
    logic        jump;
    logic        data_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vision_grid_detect dut (
        .pixel_clock_in (clk),
        .rst_in         (rst),
        .frame_x_count  (fx),
        .frame_y_count  (fy),
        .pixel_data     (pd),
        .pixel_valid    (pv),
        .cell_hits      (cell_hits),
        .lane           (lane),
        .jump           (jump),
        .data_valid     (data_valid)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        pv = 1'b0; fx = 10'd1; fy = 9'd1; pd = 16'hFFFF;
    endtask

    task automatic set_evt();
        pv = 1'b0; fx = 10'd0; fy = 9'd0; pd = 16'hFFFF;
    endtask

    task automatic px(input int x, input int y, input logic [15:0] d);
        @(posedge clk); #1;
        pv = 1'b1; fx = 10'(x); fy = 9'(y); pd = d;
    endtask

    task automatic dark_n(input int x, input int y, input int n);
        repeat (n) px(x, y, 16'h0000);
    endtask

    task automatic dark_rect(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                px(x, y, 16'h0000);
    endtask

    // Issue a frame event, then expect exactly one pulse 12 edges later carrying the given result.
    task automatic run_frame(input string tag, input logic [8:0] eh, input logic [1:0] el, input logic ej);
        int first;
        int pulses;
        logic [8:0] h;
        logic [1:0] l;
        logic j;
        @(posedge clk); #1;
        set_evt();
        first = -1; pulses = 0; h = '0; l = '0; j = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            set_idle();
            if (data_valid) begin
                pulses++;
                if (first < 0) begin
                    first = n; h = cell_hits; l = lane; j = jump;
                end
            end
        end
        check_val({tag, "_latency"}, 32'(first), 32'd12);
        check_val({tag, "_pulses"},  32'(pulses), 32'd1);
        check_val({tag, "_hits"},    32'(h), 32'(eh));
        check_val({tag, "_lane"},    32'(l), 32'(el));
        check_val({tag, "_jump"},    32'(j), 32'(ej));
    endtask

    initial begin
        int first;
        int pulses;
        logic [8:0] h;
        logic [1:0] l;
        logic j;

        rst = 1'b1;
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_hits", 32'(cell_hits), 32'h0);
        check_val("rst_lane", 32'(lane), 32'd1);
        check_val("rst_jump", 32'(jump), 32'd0);
        check_val("rst_dv",   32'(data_valid), 32'd0);
        rst = 1'b0;

        // all-green frame: nothing is foreground
        for (int x = 0; x < 100; x++) px(x, 0, 16'h07E0);
        run_frame("green", 9'h000, 2'd1, 1'b0);

        dark_rect(0, 79, 0, 79);
        run_frame("blk_tl", 9'h001, 2'd0, 1'b1);

        dark_rect(107, 212, 160, 239);
        run_frame("blk_bm", 9'h080, 2'd1, 1'b0);

        dark_n(150, 100, 63);
        run_frame("c4_63", 9'h000, 2'd1, 1'b0);
        dark_n(150, 100, 64);
        run_frame("c4_64", 9'h010, 2'd1, 1'b0);

        // held output while next frame streams in; then two-way column tie
        dark_n(10, 10, 64);
        check_val("hold_hits", 32'(cell_hits), 32'h010);
        dark_n(250, 10, 64);
        dark_n(250, 100, 64);
        dark_n(10, 200, 64);
        run_frame("tie", 9'h065, 2'd0, 1'b0);

        dark_n(300, 50, 64);
        dark_n(300, 150, 64);
        run_frame("col2", 9'h024, 2'd2, 1'b1);

        // grid boundaries and out-of-frame coordinates
        dark_n(105, 79, 64);
        dark_n(106, 80, 64);
        dark_n(213, 160, 64);
        dark_n(320, 0, 64);
        dark_n(0, 240, 64);
        run_frame("bound", 9'h111, 2'd0, 1'b0);

        // second frame event 5 edges after the first: only the empty second frame is published
        dark_n(250, 200, 64);
        @(posedge clk); #1;
        set_evt();
        first = -1; pulses = 0; h = '0; l = '0; j = 1'b0;
        for (int n = 0; n < 45; n++) begin
            @(posedge clk); #1;
            if (n == 4) set_evt();
            else        set_idle();
            if (data_valid) begin
                pulses++;
                if (first < 0) begin
                    first = n; h = cell_hits; l = lane; j = jump;
                end
            end
        end
        check_val("restart_latency", 32'(first), 32'd17);
        check_val("restart_pulses",  32'(pulses), 32'd1);
        check_val("restart_hits",    32'(h), 32'h000);
        check_val("restart_lane",    32'(l), 32'd0);
        check_val("restart_jump",    32'(j), 32'd0);

        // reset during scan: no pulse, outputs back to reset values
        dark_n(10, 100, 200);
        @(posedge clk); #1;
        set_evt();
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            set_idle();
            rst = (n == 5);
            if (data_valid) pulses++;
        end
        check_val("abort_pulses", 32'(pulses), 32'd0);
        check_val("abort_hits",   32'(cell_hits), 32'h000);
        check_val("abort_lane",   32'(lane), 32'd1);
        check_val("abort_jump",   32'(jump), 32'd0);
        run_frame("post_rst", 9'h000, 2'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
